// File: rtl/timekeeper_multialarm_pkg.sv
// ============================================================================
// Module  : timekeeper_multialarm_pkg
// Brief   : Shared encodings, BCD limits and helpers for the timekeeper core
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package timekeeper_multialarm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_NOON       = 8'h12;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
  } alarm_t;

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // BCD subtraction only works without a borrow, hence the split at 20 and 22.
  function automatic logic [7:0] to_12h(input logic [7:0] hh24);
    logic [7:0] r;
    r = hh24;
    if (hh24 == 8'h00)       r = BCD_NOON;
    else if (hh24 >= 8'h22)  r = hh24 - 8'h12;
    else if (hh24 >= 8'h20)  r = hh24 - 8'h18;
    else if (hh24 >= 8'h13)  r = hh24 - 8'h12;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timekeeper_multialarm_if.sv
// ============================================================================
// Module  : timekeeper_multialarm_if
// Brief   : Register-style write port for time and alarm programming
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface timekeeper_multialarm_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_hour_BCD;
  logic [7:0] wr_min_BCD;
  logic       wr_err;

  modport master (output wr_en, wr_addr, wr_hour_BCD, wr_min_BCD, input wr_err);
  modport slave  (input wr_en, wr_addr, wr_hour_BCD, wr_min_BCD, output wr_err);
endinterface

`default_nettype wire

// File: rtl/timekeeper_multialarm_bcd_hms_counter.sv
// ============================================================================
// Module  : bcd_hms_counter
// Brief   : 24-hour BCD hh:mm:ss registers with tick increment, load and wrap
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_hms_counter
  import timekeeper_multialarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_N,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_hh_i,
  input  logic [7:0] load_mm_i,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o,
  output logic [7:0] ss_o,
  output logic [7:0] nxt_hh_o,
  output logic [7:0] nxt_mm_o,
  output logic [7:0] nxt_ss_o,
  output logic       wrap_o
);

  logic [7:0] hh_q, mm_q, ss_q;
  logic       w_carry_s, w_carry_m;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  assign w_carry_s = (ss_q == BCD_MINSEC_MAX);
  assign w_carry_m = w_carry_s && (mm_q == BCD_MINSEC_MAX);

  assign nxt_ss_o = bcd_inc(ss_q, BCD_MINSEC_MAX);
  assign nxt_mm_o = w_carry_s ? bcd_inc(mm_q, BCD_MINSEC_MAX) : mm_q;
  assign nxt_hh_o = w_carry_m ? bcd_inc(hh_q, BCD_HOUR_MAX) : hh_q;
  assign wrap_o   = tick_i && !load_i && w_carry_m;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      hh_q <= 8'h00;
      mm_q <= 8'h00;
      ss_q <= 8'h00;
    end else if (load_i) begin
      hh_q <= load_hh_i;
      mm_q <= load_mm_i;
      ss_q <= 8'h00;
    end else if (tick_i) begin
      hh_q <= nxt_hh_o;
      mm_q <= nxt_mm_o;
      ss_q <= nxt_ss_o;
    end
  end

  assign hh_o = hh_q;
  assign mm_o = mm_q;
  assign ss_o = ss_q;

endmodule

`default_nettype wire

// File: rtl/timekeeper_multialarm.sv
// ============================================================================
// Module  : timekeeper_multialarm
// Brief   : BCD time-of-day core with multiple alarms, snooze FSM and chime
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module timekeeper_multialarm
  import timekeeper_multialarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int CHIME_SEC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_N,
  timekeeper_multialarm_if.slave wr_if,
  input  logic                  tick_1hz,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  mode_12h,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [23:0]           time_BCD,
  output logic                  pm,
  output logic                  hourly_pulse,
  output logic                  LED_hourly,
  output logic                  alarm_ring,
  output logic [3:0]            alarm_id
);

  localparam logic [3:0]  C_NUM_ALARMS = 4'(NUM_ALARMS);
  localparam logic [7:0]  C_RING_LAST  = 8'(RING_SEC - 1);
  localparam logic [11:0] C_SNZ_LOAD   = 12'(SNOOZE_MIN * 60);
  localparam logic [5:0]  C_CHIME_LOAD = 6'(CHIME_SEC);

  logic       w_wr_ok, w_time_wr, w_tick, w_wrap;
  logic [7:0] w_hh, w_mm, w_ss, w_nxt_hh, w_nxt_mm, w_nxt_ss;

  assign w_wr_ok = is_bcd(wr_if.wr_hour_BCD) && is_bcd(wr_if.wr_min_BCD)
                && (wr_if.wr_hour_BCD <= BCD_HOUR_MAX)
                && (wr_if.wr_min_BCD <= BCD_MINSEC_MAX)
                && (wr_if.wr_addr <= C_NUM_ALARMS);
  assign w_time_wr = wr_if.wr_en && w_wr_ok && (wr_if.wr_addr == 4'd0);
  // An accepted time write swallows a coincident tick entirely (no match, no count).
  assign w_tick = tick_1hz && !w_time_wr;

  bcd_hms_counter u_hms (
    .clk       (clk),
    .rst_N     (rst_N),
    .tick_i    (w_tick),
    .load_i    (w_time_wr),
    .load_hh_i (wr_if.wr_hour_BCD),
    .load_mm_i (wr_if.wr_min_BCD),
    .hh_o      (w_hh),
    .mm_o      (w_mm),
    .ss_o      (w_ss),
    .nxt_hh_o  (w_nxt_hh),
    .nxt_mm_o  (w_nxt_mm),
    .nxt_ss_o  (w_nxt_ss),
    .wrap_o    (w_wrap)
  );

  alarm_t [NUM_ALARMS-1:0] alarm_q;
  logic   [NUM_ALARMS-1:0] w_hit;
  logic   [3:0]            w_hit_id;
  logic                    w_en_cur;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      alarm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_if.wr_en && w_wr_ok && (wr_if.wr_addr == 4'(i + 1))) begin
          alarm_q[i].hh <= wr_if.wr_hour_BCD;
          alarm_q[i].mm <= wr_if.wr_min_BCD;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
      assign w_hit[gi] = w_tick && alarm_en[gi] && (w_nxt_ss == 8'h00)
                      && (alarm_q[gi].hh == w_nxt_hh) && (alarm_q[gi].mm == w_nxt_mm);
    end
  endgenerate

  // alarm_id is 1-based (matches wr_addr) so that 0 can mean "none".
  logic [1:0]  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [11:0] snz_cnt_q, snz_cnt_d;

  always_comb begin
    w_hit_id = 4'd0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_id = 4'(i + 1);
    end
    w_en_cur = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (id_q == 4'(i + 1)) w_en_cur = alarm_en[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|w_hit) begin
          state_d    = ST_RING;
          id_d       = w_hit_id;
          ring_cnt_d = 8'd0;
        end
      end
      ST_RING: begin
        if (dismiss || !w_en_cur) begin
          state_d = ST_IDLE;
          id_d    = 4'd0;
        end else if (snooze) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = C_SNZ_LOAD;
        end else if (w_tick) begin
          if (ring_cnt_q == C_RING_LAST) begin
            state_d = ST_IDLE;
            id_d    = 4'd0;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (dismiss || !w_en_cur) begin
          state_d = ST_IDLE;
          id_d    = 4'd0;
        end else if (|w_hit) begin
          state_d    = ST_RING;
          id_d       = w_hit_id;
          ring_cnt_d = 8'd0;
        end else if (w_tick) begin
          if (snz_cnt_q <= 12'd1) begin
            state_d    = ST_RING;
            ring_cnt_d = 8'd0;
          end else begin
            snz_cnt_d = snz_cnt_q - 12'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = 4'd0;
      end
    endcase
  end

  logic [5:0] chime_q;
  logic       hourly_q, wr_err_q;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q    <= ST_IDLE;
      id_q       <= 4'd0;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 12'd0;
      chime_q    <= 6'd0;
      hourly_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      hourly_q   <= w_wrap;
      wr_err_q   <= wr_if.wr_en && !w_wr_ok;
      if (w_time_wr)                       chime_q <= 6'd0;
      else if (w_wrap)                     chime_q <= C_CHIME_LOAD;
      else if (w_tick && chime_q != 6'd0)  chime_q <= chime_q - 6'd1;
    end
  end

  assign time_BCD     = {(mode_12h ? to_12h(w_hh) : w_hh), w_mm, w_ss};
  assign pm           = (w_hh >= BCD_NOON);
  assign hourly_pulse = hourly_q;
  assign LED_hourly   = (chime_q != 6'd0);
  assign alarm_ring   = (state_q == ST_RING);
  assign alarm_id     = id_q;
  assign wr_if.wr_err = wr_err_q;

endmodule

`default_nettype wire

// File: doc/timekeeper_multialarm.md
Name: timekeeper_multialarm

Overview:
- Parametrised time-of-day core for the next-generation digital clock.
- Keeps BCD hh:mm:ss from an external 1 Hz tick and supports NUM_ALARMS independently programmable alarms through one register-style write port.
- Adds a 12/24-hour display mode, a ring/snooze/dismiss alarm state machine and a timed hourly chime.
- Sits between the clock divider (tick source) and the display drive (consumes time_BCD).

Parameters:
- NUM_ALARMS, 4, number of alarm registers (1..15).
- SNOOZE_MIN, 5, snooze length in minutes (1..59).
- RING_SEC, 60, auto-stop time for an unanswered ring, in seconds (1..255).
- CHIME_SEC, 2, duration LED_hourly stays high after an hour rollover, in seconds (1..59).

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst_N  in  1  reset; asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk.
- wr_en  in  1  one-cycle write strobe.
- wr_addr  in  4  0 = current time; k = alarm k-1, for k = 1..NUM_ALARMS.
- wr_hour_BCD  in  8  hour in BCD, 24-hour form, 00..23.
- wr_min_BCD  in  8  minute in BCD, 00..59.
- alarm_en  in  NUM_ALARMS  per-alarm enable levels.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- snooze  in  1  one-cycle pulse.
- dismiss  in  1  one-cycle pulse.
- time_BCD  out  24  {hh, mm, ss} in BCD, hour formatted per mode_12h.
- pm  out  1  1 when the internal hour is 12..23; valid in both modes.
- hourly_pulse  out  1  one-cycle pulse on rollover to mm:ss = 00:00.
- LED_hourly  out  1  chime indicator.
- alarm_ring  out  1  high while in the RING state.
- alarm_id  out  4  index of the ringing or snoozed alarm; 0 when IDLE.
- wr_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (async, rst_N = 0):
  - time = 00:00:00; all alarms = 00:00; FSM = IDLE; all counters cleared.
  - Every output 0, except time_BCD = 24'h000000, or 24'h120000 when mode_12h = 1.
- Time keeping:
  - Internal 24-hour BCD digits advance on tick_1hz.
  - Carry chain: ss 59->00 carries to mm; mm 59->00 carries to hh; 23:59:59 -> 00:00:00.
  - Registered state updates on the edge that samples the tick. time_BCD and pm are combinational from that state, so they change the cycle after the tick.
- 12-hour formatting:
  - Internal hour 00 -> 12 with pm = 0.
  - Internal hour 12 -> 12 with pm = 1.
  - Internal hours 13..23 -> 01..11 with pm = 1.
  - Internal hours 01..11 unchanged, pm = 0.
- Writes:
  - A write is rejected, and pulses wr_err for one cycle, if any nibble is greater than 9, hour > 23, minute > 59, or wr_addr > NUM_ALARMS. A rejected write changes no state.
  - A valid time write loads hh:mm, sets ss = 00 and resets the chime.
  - If wr_en and tick_1hz coincide, the write wins and the tick is dropped.
  - Writing an alarm register never triggers that alarm by itself.
- Alarm match:
  - Evaluated only on a tick, against the post-increment time.
  - Condition: new ss = 00, new hh:mm equals alarm k, and alarm_en[k] = 1.
  - The lowest matching index wins.
  - alarm_ring rises in the same cycle that time_BCD shows hh:mm:00.
- Alarm FSM:
  - IDLE -> RING on a match; alarm_id is loaded and the second counter is cleared.
  - RING -> SNOOZE on snooze; the snooze counter is loaded with SNOOZE_MIN*60.
  - RING -> IDLE on dismiss, or after RING_SEC ticks.
  - RING ignores any new match.
  - SNOOZE: the counter decrements on each tick. At zero -> RING with the same id and the ring counter cleared.
  - SNOOZE -> IDLE on dismiss.
  - A new match while in SNOOZE -> RING with the new id.
  - In RING or SNOOZE, clearing alarm_en[alarm_id] -> IDLE on the next cycle.
  - If snooze and dismiss arrive in the same cycle, dismiss wins.
  - snooze and dismiss pulses received in IDLE are ignored.
- Hourly chime:
  - hourly_pulse fires on a tick-driven rollover to mm:ss = 00:00; it does not fire on a write.
  - LED_hourly is high for exactly CHIME_SEC ticks starting at that rollover. A new rollover restarts the count.

Decomposition:
- Shared package:
  - Alarm state encoding: IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2.
  - BCD limit constants: 8'h59, 8'h23, 8'h12.
  - A function that checks whether a byte is valid BCD.
- One natural sub-module: bcd_hms_counter. It holds the time registers and provides tick increment, synchronous load and a wrap flag.
- The alarm registers, the compare logic and the FSM stay in the top module.

Test Plan:
- Load time 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00. hourly_pulse fires once and LED_hourly is high for CHIME_SEC = 2 ticks.
- mode_12h = 1 at internal time 00:30:00 -> time_BCD = 24'h123000, pm = 0. At internal 13:05:00 -> 24'h010500, pm = 1.
- Write wr_addr = 0 with hour 8'h24 -> wr_err pulses and time is unchanged. Write minute 8'h5A -> wr_err pulses. Write wr_addr = NUM_ALARMS+1 -> wr_err pulses.
- Alarms 2 and 3 both set to 07:00 and enabled, time 06:59:59, one tick -> alarm_ring = 1, alarm_id = 2. With no response, after 60 ticks alarm_ring = 0.
- While ringing, pulse snooze -> SNOOZE state. After 300 ticks -> RING with the same id. Then pulse snooze and dismiss together -> IDLE and alarm_id = 0.
- A valid time write coinciding with tick_1hz -> the written value is loaded with ss = 00 and there is no increment. Asserting rst_N = 0 mid-RING -> all outputs clear immediately.
